// File: rtl/traffic_pkg.sv
// Shared types and encodings for the traffic light controller.
package traffic_pkg;

    localparam int REM_W = 7;

    // Lamp encoding is one-hot {red, yellow, green}
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [2:0] {
        HOLD,
        MAIN_GREEN,
        MAIN_YELLOW,
        ALL_RED_A,
        SIDE_GREEN,
        SIDE_YELLOW,
        ALL_RED_B
    } state_t;

    function automatic state_t next_phase(state_t s);
        case (s)
            MAIN_GREEN:  return MAIN_YELLOW;
            MAIN_YELLOW: return ALL_RED_A;
            ALL_RED_A:   return SIDE_GREEN;
            SIDE_GREEN:  return SIDE_YELLOW;
            SIDE_YELLOW: return ALL_RED_B;
            ALL_RED_B:   return MAIN_GREEN;
            default:     return ALL_RED_B;
        endcase
    endfunction

    function automatic logic [2:0] main_lamp(state_t s);
        case (s)
            MAIN_GREEN:  return GREEN;
            MAIN_YELLOW: return YELLOW;
            default:     return RED;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(state_t s);
        case (s)
            SIDE_GREEN:  return GREEN;
            SIDE_YELLOW: return YELLOW;
            default:     return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Control/status bundle between the intersection controller and its user.
interface traffic_light_ctrl_if;
    import traffic_pkg::*;

    logic             tick;
    logic             en;
    logic             ped_req;
    logic [2:0]       main_light;
    logic [2:0]       side_light;
    logic             ped_walk;
    logic [REM_W-1:0] remaining;
    logic             last;
    logic             pre_last;

    modport master (
        output tick, en, ped_req,
        input  main_light, side_light, ped_walk, remaining, last, pre_last
    );

    modport slave (
        input  tick, en, ped_req,
        output main_light, side_light, ped_walk, remaining, last, pre_last
    );

endinterface

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Loadable down-counter holding the seconds left in the current phase.
module phase_timer
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             load,
    input  logic [REM_W-1:0] load_val,
    input  logic             dec,
    output logic [REM_W-1:0] count,
    output logic             last,
    output logic             pre_last
);

    logic [REM_W-1:0] count_nxt;

    // No reset of its own: the controller asserts load during reset.
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_val;
        end else if (dec && count != '0) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count    <= count_nxt;
        last     <= (count_nxt == REM_W'(0));
        pre_last <= (count_nxt == REM_W'(1));
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer with pedestrian-shortened main green.
//   state       | meaning
//   HOLD        | disabled, both roads red, timer parked at 0
//   MAIN_GREEN  | main road flowing
//   MAIN_YELLOW | main road clearing
//   ALL_RED_A   | clearance before side road
//   SIDE_GREEN  | side road flowing, walk lamp if a request was pending
//   SIDE_YELLOW | side road clearing
//   ALL_RED_B   | clearance before main road (also the resume path)
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int pGREEN_MAIN = 30,
    parameter int pGREEN_SIDE = 20,
    parameter int pYELLOW     = 3,
    parameter int pALL_RED    = 2,
    parameter int pPED_SHORT  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_light_ctrl_if.slave  bus
);

    localparam logic [REM_W-1:0] PED_M1 = REM_W'(pPED_SHORT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             pending;
    logic             pend_eff;
    logic             phase_done;
    logic [2:0]       main_light;
    logic [2:0]       side_light;
    logic             ped_walk;
    logic             tmr_load;
    logic [REM_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic [REM_W-1:0] tmr_count;
    logic             tmr_last;
    logic             tmr_pre_last;

    function automatic logic [REM_W-1:0] phase_len_m1(state_t s);
        case (s)
            MAIN_GREEN:  return REM_W'(pGREEN_MAIN - 1);
            MAIN_YELLOW: return REM_W'(pYELLOW - 1);
            ALL_RED_A:   return REM_W'(pALL_RED - 1);
            SIDE_GREEN:  return REM_W'(pGREEN_SIDE - 1);
            SIDE_YELLOW: return REM_W'(pYELLOW - 1);
            ALL_RED_B:   return REM_W'(pALL_RED - 1);
            default:     return '0;
        endcase
    endfunction

    // A request on the same cycle counts as pending for truncation and walk.
    assign pend_eff   = pending | bus.ped_req;
    assign phase_done = bus.tick && tmr_last;

    always_comb begin
        state_nxt    = state;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        if (!rst_n) begin
            state_nxt    = MAIN_GREEN;
            tmr_load     = 1'b1;
            tmr_load_val = phase_len_m1(MAIN_GREEN);
        end else if (!bus.en) begin
            state_nxt    = HOLD;
            tmr_load     = 1'b1;
        end else if (state == HOLD) begin
            state_nxt    = ALL_RED_B;
            tmr_load     = 1'b1;
            tmr_load_val = phase_len_m1(ALL_RED_B);
        end else if (phase_done) begin
            state_nxt    = next_phase(state);
            tmr_load     = 1'b1;
            tmr_load_val = phase_len_m1(next_phase(state));
        end else if (state == MAIN_GREEN && pend_eff && tmr_count > PED_M1) begin
            tmr_load     = 1'b1;
            tmr_load_val = PED_M1;
        end else begin
            tmr_dec      = bus.tick;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= MAIN_GREEN;
            main_light <= GREEN;
            side_light <= RED;
            ped_walk   <= 1'b0;
            pending    <= 1'b0;
        end else begin
            state      <= state_nxt;
            main_light <= main_lamp(state_nxt);
            side_light <= side_lamp(state_nxt);
            if (state != SIDE_GREEN && state_nxt == SIDE_GREEN) begin
                ped_walk <= pend_eff;
                pending  <= 1'b0;
            end else begin
                ped_walk <= (state_nxt == SIDE_GREEN) ? ped_walk : 1'b0;
                pending  <= pend_eff;
            end
        end
    end

    phase_timer u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .last     (tmr_last),
        .pre_last (tmr_pre_last)
    );

    assign bus.main_light = main_light;
    assign bus.side_light = side_light;
    assign bus.ped_walk   = ped_walk;
    assign bus.remaining  = tmr_count;
    assign bus.last       = tmr_last;
    assign bus.pre_last   = tmr_pre_last;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with default timing parameters.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   armed = 1'b0;

    always #5 clk = ~clk;

    traffic_light_ctrl_if bus ();

    traffic_light_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit t, input bit p);
        @(negedge clk);
        bus.tick    = t;
        bus.ped_req = p;
        @(posedge clk);
        #1;
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
    endtask

    // One tick period: three idle cycles, then the tick cycle.
    task automatic tk(input bit p);
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b1, p);
    endtask

    task automatic ticks(input int n);
        repeat (n) tk(1'b0);
    endtask

    task automatic see(input string tag, input logic [2:0] m, input logic [2:0] s, input int rem);
        chk({tag, "_main"}, bus.main_light, m);
        chk({tag, "_side"}, bus.side_light, s);
        chk({tag, "_rem"}, bus.remaining, rem);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("onehot_main", $onehot(bus.main_light), 1);
            chk("onehot_side", $onehot(bus.side_light), 1);
        end
    end

    initial begin
        bus.tick    = 1'b0;
        bus.en      = 1'b1;
        bus.ped_req = 1'b0;

        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        armed = 1'b1;
        see("reset", GREEN, RED, 29);
        chk("reset_walk", bus.ped_walk, 0);
        chk("reset_last", bus.last, 0);
        rst_n = 1'b1;

        for (int k = 1; k <= 29; k++) begin
            tk(1'b0);
            chk("mg_count", bus.remaining, 29 - k);
            if (k == 28) chk("mg_pre_last", bus.pre_last, 1);
            if (k == 29) chk("mg_last", bus.last, 1);
        end
        tk(1'b0);
        see("main_yellow", YELLOW, RED, 2);
        ticks(3);
        see("all_red_a", RED, RED, 1);
        ticks(2);
        see("side_green", RED, GREEN, 19);
        chk("sg_walk_off", bus.ped_walk, 0);

        cyc(1'b0, 1'b1);
        chk("sg_req_walk", bus.ped_walk, 0);
        chk("sg_req_rem", bus.remaining, 19);
        ticks(5);
        chk("sg_rem14", bus.remaining, 14);

        bus.en = 1'b0;
        cyc(1'b0, 1'b0);
        see("hold", RED, RED, 0);
        chk("hold_walk", bus.ped_walk, 0);
        tk(1'b0);
        tk(1'b0);
        see("hold_stay", RED, RED, 0);
        bus.en = 1'b1;
        cyc(1'b0, 1'b0);
        see("all_red_b", RED, RED, 1);
        tk(1'b0);
        chk("arb_rem0", bus.remaining, 0);
        tk(1'b0);
        see("resume_mg", GREEN, RED, 29);
        cyc(1'b0, 1'b0);
        chk("retained_trunc", bus.remaining, 4);
        ticks(4);
        chk("trunc_rem0", bus.remaining, 0);
        tk(1'b0);
        see("trunc_my", YELLOW, RED, 2);
        ticks(5);
        see("sg_walk", RED, GREEN, 19);
        chk("sg_walk_on", bus.ped_walk, 1);
        ticks(19);
        chk("sg_walk_hold", bus.ped_walk, 1);
        tk(1'b0);
        see("side_yellow", RED, YELLOW, 2);
        chk("sy_walk", bus.ped_walk, 0);
        ticks(3);
        see("arb2", RED, RED, 1);
        ticks(2);
        see("mg2", GREEN, RED, 29);
        cyc(1'b0, 1'b0);
        chk("no_pend", bus.remaining, 29);

        ticks(9);
        chk("mg_rem20", bus.remaining, 20);
        cyc(1'b0, 1'b1);
        chk("ped20", bus.remaining, 4);
        ticks(4);
        tk(1'b0);
        see("ped20_my", YELLOW, RED, 2);
        ticks(5);
        see("ped20_sg", RED, GREEN, 19);
        chk("ped20_walk", bus.ped_walk, 1);

        ticks(25);
        see("mg3", GREEN, RED, 29);
        ticks(26);
        chk("mg_rem3", bus.remaining, 3);
        tk(1'b1);
        chk("ped3_tick", bus.remaining, 2);
        ticks(2);
        tk(1'b0);
        see("ped3_my", YELLOW, RED, 2);
        ticks(5);
        see("ped3_sg", RED, GREEN, 19);
        chk("ped3_walk", bus.ped_walk, 1);

        cyc(1'b0, 1'b1);
        ticks(20);
        see("sy_pend", RED, YELLOW, 2);
        rst_n = 1'b0;
        cyc(1'b1, 1'b1);
        see("rst_sy", GREEN, RED, 29);
        chk("rst_sy_walk", bus.ped_walk, 0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0);
        chk("rst_no_pend", bus.remaining, 29);
        ticks(35);
        see("rst_sg", RED, GREEN, 19);
        chk("rst_sg_walk", bus.ped_walk, 0);

        ticks(25);
        see("mg4", GREEN, RED, 29);
        tk(1'b1);
        chk("tick_ped_prio", bus.remaining, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter pGREEN_MAIN, default 30, main-road green duration in seconds (range 1..99).
REQ-002 Parameter pGREEN_SIDE, default 20, side-road green duration in seconds (range 1..99).
REQ-003 Parameter pYELLOW, default 3, yellow duration in seconds for either road (range 1..99).
REQ-004 Parameter pALL_RED, default 2, all-red clearance duration in seconds (range 1..99).
REQ-005 Parameter pPED_SHORT, default 5, truncated main-green remainder in seconds on pedestrian request (range 1..99).
REQ-006 Clock and reset: one clock; reset is synchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 tick  input  1  one-cycle one-second strobe; all timing advances only on cycles with tick=1.
REQ-010 en  input  1  controller enable; low forces the HOLD state.
REQ-011 ped_req  input  1  pedestrian request pulse, any length.
REQ-012 main_light  output  3  one-hot {red,yellow,green} for the main road.
REQ-013 side_light  output  3  one-hot {red,yellow,green} for the side road.
REQ-014 ped_walk  output  1  walk indication for the pedestrian crossing of the main road.
REQ-015 remaining  output  7  seconds remaining in the current phase minus one (0 = last second).
REQ-016 last  output  1  high when remaining==0; pre_last high when remaining==1 (output, 1 bit).

Function
REQ-017 States: HOLD, MAIN_GREEN, MAIN_YELLOW, ALL_RED_A, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B.
REQ-018 On entry to a phase, remaining loads its duration minus one; the loaded value is visible the cycle after the transition.
REQ-019 In any timed state, tick with remaining>0 decrements remaining by 1; tick with remaining==0 moves to the next state.
REQ-020 Sequence: MAIN_GREEN -> MAIN_YELLOW -> ALL_RED_A -> SIDE_GREEN -> SIDE_YELLOW -> ALL_RED_B -> MAIN_GREEN.
REQ-021 Lights: MAIN_GREEN main=green/side=red; MAIN_YELLOW main=yellow/side=red; SIDE_GREEN main=red/side=green; SIDE_YELLOW main=red/side=yellow; ALL_RED_x and HOLD both red.
REQ-022 ped_req sets an internal pending flag; the flag clears on entry to SIDE_GREEN.
REQ-023 In MAIN_GREEN, with pending set and remaining > pPED_SHORT-1, remaining loads pPED_SHORT-1 on the next cycle, taking priority over a coincident tick decrement.
REQ-024 ped_walk is high throughout SIDE_GREEN when pending was set on entry to that state, otherwise low.
REQ-025 ped_req arriving in SIDE_GREEN sets pending for the next cycle; it does not affect the current SIDE_GREEN.
REQ-026 en=0 moves any state to HOLD on the next cycle; remaining is 0 in HOLD; pending is retained.
REQ-027 en=1 in HOLD moves to ALL_RED_B (remaining=pALL_RED-1), so service resumes at MAIN_GREEN after clearance.
REQ-028 Outputs are registered and glitch-free; exactly one bit of each light output is high in every cycle.

Reset
REQ-029 rst_n=0 at a clock edge forces MAIN_GREEN, remaining=pGREEN_MAIN-1, pending=0, ped_walk=0, main_light=green, side_light=red; it overrides en, tick and ped_req.
REQ-030 Reset asserted mid-phase discards any pending request and any partial count.

Structure
REQ-031 Package traffic_pkg holds the state enum, the light encoding constants (RED/YELLOW/GREEN one-hot) and the 7-bit remaining width constant.
REQ-032 The remaining counter is one sub-module, phase_timer: a loadable down-counter with load, load_val, dec, count, last and pre_last.

Verification
REQ-033 Defaults, reset released, en=1, tick every 4 cycles -> MAIN_GREEN for 30 ticks, MAIN_YELLOW for 3 ticks, ALL_RED_A for 2 ticks, SIDE_GREEN for 20 ticks; remaining counts 29..0.
REQ-034 ped_req while remaining=20 in MAIN_GREEN -> remaining=4 the next cycle, MAIN_YELLOW after 5 further ticks, ped_walk=1 throughout the following SIDE_GREEN.
REQ-035 ped_req while remaining=3 in MAIN_GREEN -> no truncation; ped_walk=1 in the next SIDE_GREEN.
REQ-036 en=0 during SIDE_GREEN -> HOLD next cycle with both roads red; en=1 -> ALL_RED_B with remaining=1, then MAIN_GREEN after 2 ticks.
REQ-037 rst_n=0 during SIDE_YELLOW with a request pending -> MAIN_GREEN with remaining=29, pending cleared, ped_walk=0 in the next SIDE_GREEN.
REQ-038 tick coincident with the state transition cycle and with ped_req -> transition and truncation rules as in REQ-019 and REQ-023; assertion: each light output is one-hot in every cycle.
